trace_term_collector: RTL

//  Multi-core simulation monitor for system_noc: watches per-core mor1kx execution traces, decodes l.nop simulation hooks.

---
 rtl/trace_term_collector_pkg.sv | 33 +++
 rtl/trace_term_collector_fifo.sv | 59 +++++
 rtl/trace_term_collector.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/trace_term_collector_pkg.sv
// Shared constants, hook decode and width helper for the trace termination collector.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package trace_term_collector_pkg;

  // l.nop simulation hooks recognised in the retired-instruction stream
  localparam logic [31:0] NOP_EXIT = 32'h1500_0001;
  localparam logic [31:0] NOP_PUTC = 32'h1500_0004;

  typedef enum logic [1:0] {
    HOOK_NONE,
    HOOK_EXIT,
    HOOK_PUTC
  } hook_e;

  // Width of an index into n items, never narrower than one bit
  function automatic int core_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Classify one retired instruction; only strobed instructions count
  function automatic hook_e decode_hook(input logic vld, input logic [31:0] insn);
    hook_e h;
    h = HOOK_NONE;
    if (vld && (insn == NOP_EXIT)) begin
      h = HOOK_EXIT;
    end else if (vld && (insn == NOP_PUTC)) begin
      h = HOOK_PUTC;
    end
    return h;
  endfunction

endpackage

// File: rtl/trace_term_collector_fifo.sv
// Character FIFO: power-of-two ring buffer with wrap-bit pointers.
// Latency: a push is visible on the read side the following cycle.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module trace_term_collector_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     push_dat_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output T     pop_dat_o
);

  localparam int AW = $clog2(DEPTH);

  T            mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  // Extra MSB distinguishes full from empty when the index bits match
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop_i && !empty_o;
  assign do_push   = push_i && (!full_o || do_pop);
  // Head entry comes straight from storage; idle output is forced to zero
  assign pop_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state: natural wrap at DEPTH since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers, cleared on reset so the FIFO starts empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care until a pointer covers them
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/trace_term_collector.sv
// Multi-core trace monitor: decodes exit/putc hooks, streams chars, watchdog, drained sim_done.
// Latency: exit -> core_done +1 cycle; putc -> out_valid +2 cycles on an idle system.
// Backpressure: out_ready stalls the FIFO; a putc into a still-full pending slot is dropped (overflow).
module trace_term_collector
  import trace_term_collector_pkg::*;
#(
  parameter int          NUM_CORES       = 4,
  parameter int          FIFO_DEPTH      = 8,
  parameter int unsigned WATCHDOG_CYCLES = 1000000,
  localparam int         CORE_W          = core_w(NUM_CORES)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CORES-1:0]    trace_valid_i,
  input  logic [NUM_CORES*32-1:0] trace_insn_i,
  input  logic [NUM_CORES*32-1:0] trace_r3_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [CORE_W-1:0]       out_core_o,
  output logic [7:0]              out_char_o,
  output logic [NUM_CORES-1:0]    core_done_o,
  output logic [NUM_CORES*32-1:0] exit_code_o,
  output logic                    exit_error_o,
  output logic                    overflow_o,
  output logic                    timeout_o,
  output logic                    sim_done_o
);

  typedef struct packed {
    logic [CORE_W-1:0] core_id;
    logic [7:0]        chr;
  } putc_entry_t;

  localparam logic [31:0]       WD_LIMIT  = 32'(WATCHDOG_CYCLES);
  localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

  logic [NUM_CORES-1:0]    is_exit, is_putc;
  logic [NUM_CORES-1:0]    slot_full_q, slot_full_d;
  putc_entry_t             slot_dat_q [NUM_CORES];
  putc_entry_t             slot_dat_d [NUM_CORES];
  logic [NUM_CORES-1:0]    grant;
  logic                    grant_vld;
  logic [CORE_W-1:0]       grant_idx, scan_idx;
  logic [CORE_W-1:0]       last_q, last_d;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop, can_push;
  putc_entry_t             push_dat, fifo_dat;
  logic [NUM_CORES-1:0]    done_q, done_d;
  logic [NUM_CORES*32-1:0] code_q, code_d;
  logic                    err_q, err_d;
  logic                    ovf_q, ovf_d;
  logic                    to_q, to_d, to_set;
  logic                    sim_q, sim_d, drained;
  logic [31:0]             wd_q, wd_d;

  // Per-core hook decode from the retired-instruction strobes
  always_comb begin
    is_exit = '0;
    is_putc = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      is_exit[i] = (decode_hook(trace_valid_i[i], trace_insn_i[32*i +: 32]) == HOOK_EXIT);
      is_putc[i] = (decode_hook(trace_valid_i[i], trace_insn_i[32*i +: 32]) == HOOK_PUTC);
    end
  end

  // Round-robin grant of one full pending slot, scanning from last grant + 1
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    scan_idx  = '0;
    if (can_push) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        scan_idx = CORE_W'((int'(last_q) + 1 + k) % NUM_CORES);
        if (!grant_vld && slot_full_q[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    grant     = grant_vld ? (NUM_CORES'(1) << grant_idx) : '0;
    last_d    = grant_vld ? grant_idx : last_q;
    fifo_push = grant_vld;
    push_dat  = slot_dat_q[grant_idx];
  end

  // Pending slots: grant frees a slot the same cycle a new putc may refill it
  always_comb begin
    slot_full_d = slot_full_q;
    slot_dat_d  = slot_dat_q;
    ovf_d       = ovf_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) slot_full_d[i] = 1'b0;
      if (is_putc[i]) begin
        if (slot_full_q[i] && !grant[i]) begin
          ovf_d = 1'b1;
        end else begin
          slot_full_d[i]        = 1'b1;
          slot_dat_d[i].core_id = CORE_W'(i);
          slot_dat_d[i].chr     = trace_r3_i[32*i +: 8];
        end
      end
    end
  end

  // Exit capture: first exit per core wins, later exits leave the code alone
  always_comb begin
    done_d = done_q;
    code_d = code_q;
    err_d  = err_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (is_exit[i] && !done_q[i]) begin
        done_d[i]          = 1'b1;
        code_d[32*i +: 32] = trace_r3_i[32*i +: 32];
        if (trace_r3_i[32*i +: 32] != 32'd0) err_d = 1'b1;
      end
    end
  end

  // Idle watchdog: cleared by any activity, saturates at the limit, frozen once all cores exit
  always_comb begin
    wd_d   = wd_q;
    to_set = 1'b0;
    if ((WATCHDOG_CYCLES != 0) && !(&done_q)) begin
      if (|trace_valid_i) begin
        wd_d = '0;
      end else if (wd_q != WD_LIMIT) begin
        wd_d = wd_q + 32'd1;
      end
      to_set = (wd_d == WD_LIMIT);
    end
    to_d = to_q | to_set;
  end

  // Completion: drained system or watchdog expiry; the expiry edge also sets sim_done directly
  always_comb begin
    drained = (&done_q) && fifo_empty && !(|slot_full_q);
    sim_d   = sim_q | to_q | to_set | drained;
  end

  // All monitor state; reset discards queued characters and status
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_full_q <= '0;
      for (int i = 0; i < NUM_CORES; i++) slot_dat_q[i] <= '0;
      last_q      <= LAST_CORE;
      done_q      <= '0;
      code_q      <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
      sim_q       <= 1'b0;
      wd_q        <= '0;
    end else begin
      slot_full_q <= slot_full_d;
      slot_dat_q  <= slot_dat_d;
      last_q      <= last_d;
      done_q      <= done_d;
      code_q      <= code_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      sim_q       <= sim_d;
      wd_q        <= wd_d;
    end
  end

  assign can_push = !fifo_full || fifo_pop;
  assign fifo_pop = !fifo_empty && out_ready_i;

  trace_term_collector_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (putc_entry_t)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (fifo_push),
    .push_dat_i (push_dat),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .pop_dat_o  (fifo_dat)
  );

  assign out_valid_o  = !fifo_empty;
  assign out_core_o   = fifo_dat.core_id;
  assign out_char_o   = fifo_dat.chr;
  assign core_done_o  = done_q;
  assign exit_code_o  = code_q;
  assign exit_error_o = err_q;
  assign overflow_o   = ovf_q;
  assign timeout_o    = to_q;
  assign sim_done_o   = sim_q;

endmodule
